ife_dispatch_n: RTL and testbench

IFE_DISPATCH_N -- requirements
Module: ife_dispatch_n

---
 rtl/ife_pkg.sv | 10 +
 rtl/ife_block_fifo.sv | 51 +++++
 rtl/ife_dispatch_n.sv | 152 +++++++++++++++
 tb/tb_ife_dispatch_n.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ife_pkg.sv
// Shared definitions for the instruction-fetch block dispatcher.
package ife_pkg;
  localparam int INSTR_W             = 32;
  localparam int DEF_NUM_CORES       = 2;
  localparam int DEF_WORDS_PER_BLOCK = 4;
  localparam int DEF_ID_W            = 8;
  localparam int DEF_FIFO_DEPTH      = 4;

  typedef enum logic [1:0] {S_IDLE, S_PAR, S_DRAIN, S_SER} disp_state_e;
endpackage

// File: rtl/ife_block_fifo.sv
// Block queue with valid/ready push and pop strobe; exposes the head and the
// entry behind it so the dispatcher can look one block ahead when it pops.
module ife_block_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] next_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic             do_push, do_pop;

  assign full       = count == CW'(DEPTH);
  assign empty      = count == '0;
  assign push_ready = !full;
  // A pop in the same cycle does not free a slot for a push while full.
  assign do_push    = push_valid && !full;
  assign do_pop     = pop && !empty;
  assign rd_nxt     = rd_ptr + AW'(1);
  assign head_data  = mem[rd_ptr];
  assign next_data  = mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/ife_dispatch_n.sv
// Dispatches queued instruction blocks to NUM_CORES cores: parallel blocks go
// round-robin to free cores, serial blocks wait for a full drain and run alone.
module ife_dispatch_n
  import ife_pkg::*;
#(
  parameter int NUM_CORES       = DEF_NUM_CORES,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int ID_W            = DEF_ID_W,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ID_W-1:0]                    in_block_id,
  input  logic [WORDS_PER_BLOCK*INSTR_W-1:0] in_block_data,
  input  logic                               in_parallel,
  input  logic [NUM_CORES-1:0]               core_busy,
  input  logic [NUM_CORES-1:0]               core_commit,
  output logic [NUM_CORES-1:0]               dispatch_valid,
  output logic [ID_W-1:0]                    dispatch_block_id,
  output logic [WORDS_PER_BLOCK*INSTR_W-1:0] dispatch_block_data,
  output logic                               commit_valid,
  output logic [NUM_CORES-1:0]               pending,
  output logic                               err_spurious
);
  localparam int BLK_W = WORDS_PER_BLOCK * INSTR_W;
  localparam int ENT_W = 1 + ID_W + BLK_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RR_W  = $clog2(NUM_CORES);

  typedef struct packed {
    logic            par;
    logic [ID_W-1:0] id;
    logic [BLK_W-1:0] data;
  } blk_t;

  blk_t                 in_blk, head, nxt;
  logic [CNT_W-1:0]     count;
  logic                 empty, full, push, pop;
  disp_state_e          state_q, state_d, after_pop;
  logic [RR_W-1:0]      rr_q, rr_d, rr_win, lo_win, hi_win;
  logic                 lo_found, hi_found;
  logic [NUM_CORES-1:0] pending_q, elig, grant;
  logic                 pend_nz_q;

  assign in_blk = {in_parallel, in_block_id, in_block_data};
  assign push   = in_valid && !full;

  ife_block_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_blk),
    .pop        (pop),
    .head_data  (head),
    .next_data  (nxt),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  function automatic disp_state_e head_state(input logic par);
    return par ? S_PAR : S_DRAIN;
  endfunction

  assign elig = ~core_busy & ~pending_q;

  // Round-robin: first eligible core at/after rr_q, else the lowest eligible one.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_win   = '0;
    hi_win   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (elig[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_win   = RR_W'(i);
      end
      if (elig[i] && RR_W'(i) >= rr_q && !hi_found) begin
        hi_found = 1'b1;
        hi_win   = RR_W'(i);
      end
    end
  end
  assign rr_win = hi_found ? hi_win : lo_win;

  // Head state once the current head is popped, including a same-cycle push.
  assign after_pop = (count > CNT_W'(1)) ? head_state(nxt.par) :
                     push                ? head_state(in_parallel) : S_IDLE;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    pop     = 1'b0;
    grant   = '0;
    case (state_q)
      S_IDLE: if (!empty) state_d = head_state(head.par);
      S_PAR: begin
        if (empty) begin
          state_d = S_IDLE;
        end else if (lo_found) begin
          grant[rr_win] = 1'b1;
          pop           = 1'b1;
          rr_d          = (rr_win == RR_W'(NUM_CORES - 1)) ? '0 : rr_win + RR_W'(1);
          state_d       = after_pop;
        end
      end
      S_DRAIN: begin
        if (pending_q == '0 && core_busy == '0 && !empty) begin
          grant[0] = 1'b1;
          pop      = 1'b1;
          state_d  = S_SER;
        end
      end
      S_SER: begin
        if (pending_q == '0) state_d = empty ? S_IDLE : head_state(head.par);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= S_IDLE;
      rr_q                <= '0;
      pending_q           <= '0;
      pend_nz_q           <= 1'b0;
      commit_valid        <= 1'b0;
      err_spurious        <= 1'b0;
      dispatch_valid      <= '0;
      dispatch_block_id   <= '0;
      dispatch_block_data <= '0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      pending_q      <= (pending_q & ~core_commit) | grant;
      pend_nz_q      <= |pending_q;
      // Fires the cycle after pending has been observed dropping to zero.
      commit_valid   <= pend_nz_q && (pending_q == '0);
      err_spurious   <= err_spurious | (|(core_commit & ~pending_q));
      dispatch_valid <= grant;
      if (|grant) begin
        dispatch_block_id   <= head.id;
        dispatch_block_data <= head.data;
      end
    end
  end

  assign pending = pending_q;
endmodule

// File: tb/tb_ife_dispatch_n.sv
// Bench for ife_dispatch_n: directed table and sequences on a 2-core instance,
// round-robin and randomized model comparison on a 4-core instance.
module tb_ife_dispatch_n;
  localparam int WPB = 4, IDW = 8, DEPTH = 4, DW = WPB * 32;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           a_vld, a_rdy, a_par, a_cv, a_err;
  logic [IDW-1:0] a_id, a_did;
  logic [DW-1:0]  a_data, a_ddata;
  logic [1:0]     a_busy, a_com, a_dv, a_pend;

  logic           b_vld, b_rdy, b_par, b_cv, b_err;
  logic [IDW-1:0] b_id, b_did;
  logic [DW-1:0]  b_data, b_ddata;
  logic [3:0]     b_busy, b_com, b_dv, b_pend;

  ife_dispatch_n u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_ready(a_rdy),
    .in_block_id(a_id), .in_block_data(a_data), .in_parallel(a_par),
    .core_busy(a_busy), .core_commit(a_com), .dispatch_valid(a_dv),
    .dispatch_block_id(a_did), .dispatch_block_data(a_ddata),
    .commit_valid(a_cv), .pending(a_pend), .err_spurious(a_err));

  ife_dispatch_n #(.NUM_CORES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_ready(b_rdy),
    .in_block_id(b_id), .in_block_data(b_data), .in_parallel(b_par),
    .core_busy(b_busy), .core_commit(b_com), .dispatch_valid(b_dv),
    .dispatch_block_id(b_did), .dispatch_block_data(b_ddata),
    .commit_valid(b_cv), .pending(b_pend), .err_spurious(b_err));

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [IDW-1:0] id);
    logic [DW-1:0] d = '0;
    for (int w = 0; w < WPB; w++) d[w*32 +: 32] = {id, 8'(w), 16'hC0DE};
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_vld = 0; a_id = 0; a_par = 0; a_data = 0; a_busy = 0; a_com = 0;
    b_vld = 0; b_id = 0; b_par = 0; b_data = 0; b_busy = 0; b_com = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_a(input logic [IDW-1:0] id, input logic par);
    chk("push_a ready", a_rdy, 1'b1);
    a_vld = 1; a_id = id; a_par = par; a_data = mkdata(id);
    step();
    a_vld = 0;
  endtask

  task automatic push_b(input logic [IDW-1:0] id, input logic par);
    chk("push_b ready", b_rdy, 1'b1);
    b_vld = 1; b_id = id; b_par = par; b_data = mkdata(id);
    step();
    b_vld = 0;
  endtask

  task automatic wait_dv_b(input string nm, input logic [3:0] edv, input logic [IDW-1:0] eid);
    int n = 0;
    while (b_dv == 4'd0 && n < 20) begin step(); n++; end
    chk({nm, " dv"}, b_dv, edv);
    chk({nm, " id"}, b_did, eid);
  endtask

  // Directed vectors: inputs before an edge, outputs expected after it.
  typedef struct {
    logic vld; logic [IDW-1:0] id; logic par; logic [1:0] busy, com;
    logic rdy; logic [1:0] dv; logic [IDW-1:0] did; logic [1:0] pend; logic cv, err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic vld, input int id, input logic par,
                              input logic [1:0] busy, input logic [1:0] com,
                              input logic rdy, input logic [1:0] dv, input int did,
                              input logic [1:0] pend, input logic cv, input logic err);
    vec_t v;
    v.vld = vld; v.id = IDW'(id); v.par = par; v.busy = busy; v.com = com;
    v.rdy = rdy; v.dv = dv; v.did = IDW'(did); v.pend = pend; v.cv = cv; v.err = err;
    tbl.push_back(v);
  endfunction

  // Reference model for the 4-core instance.
  typedef enum {M_IDLE, M_PAR, M_DRAIN, M_SER} mphase_t;
  typedef struct { logic par; logic [IDW-1:0] id; logic [DW-1:0] data; } mblk_t;
  mblk_t          mq[$];
  mphase_t        mph;
  int             mrr;
  bit [3:0]       mpend;
  logic [3:0]     e_dv;
  logic [IDW-1:0] e_id;
  logic [DW-1:0]  e_data;
  bit             e_cv, e_err, mzero;

  task automatic model_reset();
    mq.delete(); mph = M_IDLE; mrr = 0; mpend = 0;
    e_dv = 0; e_id = 0; e_data = 0; e_cv = 0; e_err = 0; mzero = 0;
  endtask

  function automatic mphase_t head_phase();
    if (mq.size() == 0) return M_IDLE;
    return mq[0].par ? M_PAR : M_DRAIN;
  endfunction

  task automatic model_step(input logic vld, input logic [IDW-1:0] id, input logic par,
                            input logic [DW-1:0] data, input logic [3:0] busy,
                            input logic [3:0] com);
    int g = -1;
    bit acc;
    bit [3:0] np;
    mblk_t blk;
    acc = vld && (mq.size() < DEPTH);
    case (mph)
      M_IDLE:  if (mq.size() != 0) mph = head_phase();
      M_PAR:   for (int k = 0; k < 4; k++) begin
                 int c = (mrr + k) % 4;
                 if (g < 0 && !busy[c] && !mpend[c]) g = c;
               end
      M_DRAIN: if (mpend == 0 && busy == 0) g = 0;
      M_SER:   if (mpend == 0) mph = head_phase();
    endcase
    if (g >= 0) begin
      blk = mq.pop_front();
      e_id = blk.id; e_data = blk.data;
    end
    if (acc) mq.push_back('{par, id, data});
    if (g >= 0 && mph == M_PAR) begin
      mrr = (g + 1) % 4;
      mph = head_phase();
    end else if (g >= 0) begin
      mph = M_SER;
    end
    e_dv = (g >= 0) ? 4'(1 << g) : 4'd0;
    np = mpend & ~com;
    if (g >= 0) np[g] = 1'b1;
    e_err = e_err | (|(com & ~mpend));
    e_cv  = mzero;
    mzero = (mpend != 0) && (np == 0);
    mpend = np;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst rdy", a_rdy, 1'b1);     chk("rst dv", a_dv, 2'b00);
    chk("rst did", a_did, 8'd0);     chk("rst data", a_ddata, '0);
    chk("rst pend", a_pend, 2'b00);  chk("rst cv", a_cv, 1'b0);
    chk("rst err", a_err, 1'b0);     chk("rst4 dv", b_dv, 4'd0);

    //  vld id par busy  com    rdy dv   did pend  cv err
    add(1, 1, 1, 2'b00, 2'b00,  1, 2'b00, 0, 2'b00, 0, 0);
    add(1, 2, 1, 2'b00, 2'b00,  1, 2'b00, 0, 2'b00, 0, 0);
    add(1, 3, 1, 2'b00, 2'b00,  1, 2'b01, 1, 2'b01, 0, 0);
    add(1, 4, 1, 2'b00, 2'b00,  1, 2'b10, 2, 2'b11, 0, 0);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b00, 2, 2'b11, 0, 0);
    add(0, 0, 0, 2'b00, 2'b01,  1, 2'b00, 2, 2'b10, 0, 0);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b01, 3, 2'b11, 0, 0);
    add(0, 0, 0, 2'b00, 2'b10,  1, 2'b00, 3, 2'b01, 0, 0);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b10, 4, 2'b11, 0, 0);
    add(0, 0, 0, 2'b00, 2'b11,  1, 2'b00, 4, 2'b00, 0, 0);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b00, 4, 2'b00, 1, 0);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b00, 4, 2'b00, 0, 0);
    add(0, 0, 0, 2'b00, 2'b10,  1, 2'b00, 4, 2'b00, 0, 1);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b00, 4, 2'b00, 0, 1);
    add(1, 5, 1, 2'b10, 2'b00,  1, 2'b00, 4, 2'b00, 0, 1);
    add(1, 6, 0, 2'b10, 2'b00,  1, 2'b00, 4, 2'b00, 0, 1);
    add(0, 0, 0, 2'b10, 2'b00,  1, 2'b01, 5, 2'b01, 0, 1);
    add(0, 0, 0, 2'b10, 2'b00,  1, 2'b00, 5, 2'b01, 0, 1);
    add(0, 0, 0, 2'b10, 2'b01,  1, 2'b00, 5, 2'b00, 0, 1);
    add(0, 0, 0, 2'b10, 2'b00,  1, 2'b00, 5, 2'b00, 1, 1);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b01, 6, 2'b01, 0, 1);
    add(1, 7, 1, 2'b00, 2'b00,  1, 2'b00, 6, 2'b01, 0, 1);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b00, 6, 2'b01, 0, 1);
    add(0, 0, 0, 2'b00, 2'b01,  1, 2'b00, 6, 2'b00, 0, 1);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b00, 6, 2'b00, 1, 1);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b10, 7, 2'b10, 0, 1);
    add(0, 0, 0, 2'b00, 2'b10,  1, 2'b00, 7, 2'b00, 0, 1);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b00, 7, 2'b00, 1, 1);
    add(0, 0, 0, 2'b00, 2'b00,  1, 2'b00, 7, 2'b00, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      a_vld = tbl[i].vld; a_id = tbl[i].id; a_par = tbl[i].par;
      a_data = tbl[i].vld ? mkdata(tbl[i].id) : '0;
      a_busy = tbl[i].busy; a_com = tbl[i].com;
      step();
      chk($sformatf("tbl[%0d] rdy", i), a_rdy, tbl[i].rdy);
      chk($sformatf("tbl[%0d] dv", i), a_dv, tbl[i].dv);
      chk($sformatf("tbl[%0d] did", i), a_did, tbl[i].did);
      chk($sformatf("tbl[%0d] data", i), a_ddata, (tbl[i].did == 0) ? '0 : mkdata(tbl[i].did));
      chk($sformatf("tbl[%0d] pend", i), a_pend, tbl[i].pend);
      chk($sformatf("tbl[%0d] cv", i), a_cv, tbl[i].cv);
      chk($sformatf("tbl[%0d] err", i), a_err, tbl[i].err);
    end
    a_vld = 0; a_busy = 0; a_com = 0;

    // Queue fills with both cores busy; fifth block waits for a pop.
    do_reset();
    a_busy = 2'b11;
    for (int n = 0; n < 4; n++) push_a(IDW'(10 + n), 1'b1);
    chk("full rdy", a_rdy, 1'b0);
    a_vld = 1; a_id = 8'd14; a_par = 1; a_data = mkdata(8'd14);
    repeat (3) begin
      step();
      chk("full hold rdy", a_rdy, 1'b0);
      chk("full hold dv", a_dv, 2'b00);
    end
    a_busy = 2'b10;
    step();
    chk("full pop dv", a_dv, 2'b01);
    chk("full pop id", a_did, 8'd10);
    chk("full pop no push", a_rdy, 1'b1);
    step();
    chk("full fifth accepted", a_rdy, 1'b0);
    a_vld = 0;

    // Asynchronous reset while a serial block runs with three queued.
    do_reset();
    push_a(8'd20, 1'b0);
    push_a(8'd21, 1'b1);
    push_a(8'd22, 1'b1);
    push_a(8'd23, 1'b1);
    a_com = 2'b10;
    step();
    a_com = 2'b00;
    chk("ser pend", a_pend, 2'b01);
    chk("ser did", a_did, 8'd20);
    chk("ser err", a_err, 1'b1);
    chk("ser rdy", a_rdy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst dv", a_dv, 2'b00);   chk("arst did", a_did, 8'd0);
    chk("arst data", a_ddata, '0); chk("arst pend", a_pend, 2'b00);
    chk("arst cv", a_cv, 1'b0);    chk("arst err", a_err, 1'b0);
    chk("arst rdy", a_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("post rst dv", a_dv, 2'b00);
      chk("post rst pend", a_pend, 2'b00);
      chk("post rst cv", a_cv, 1'b0);
    end

    // Round-robin on four cores: rr at 2 with core 2 busy grants core 3.
    do_reset();
    push_b(8'd30, 1'b1);
    push_b(8'd31, 1'b1);
    wait_dv_b("rr first", 4'b0001, 8'd30);
    step();
    chk("rr second dv", b_dv, 4'b0010);
    chk("rr second id", b_did, 8'd31);
    b_com = 4'b0011;
    step();
    b_com = 4'b0000;
    chk("rr commit pend", b_pend, 4'b0000);
    b_busy = 4'b0100;
    push_b(8'd32, 1'b1);
    wait_dv_b("rr skip busy", 4'b1000, 8'd32);
    push_b(8'd33, 1'b1);
    wait_dv_b("rr wrap", 4'b0001, 8'd33);
    chk("rr pend", b_pend, 4'b1001);

    // Randomized comparison against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      chk("rnd rdy", b_rdy, mq.size() < DEPTH);
      chk("rnd dv", b_dv, e_dv);
      chk("rnd did", b_did, e_id);
      chk("rnd data", b_ddata, e_data);
      chk("rnd pend", b_pend, mpend);
      chk("rnd cv", b_cv, e_cv);
      chk("rnd err", b_err, e_err);
      b_vld = 1'($urandom_range(0, 1));
      b_id  = IDW'($urandom);
      b_par = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < WPB; w++) b_data[w*32 +: 32] = $urandom;
      for (int k = 0; k < 4; k++) begin
        b_busy[k] = ($urandom_range(0, 3) == 0);
        b_com[k]  = mpend[k] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
      end
      model_step(b_vld, b_id, b_par, b_data, b_busy, b_com);
      step();
    end
    b_vld = 0; b_busy = 0; b_com = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
